// File: rtl/vc_queue.sv
// vc_queue: multi-channel input buffer for a switch port.
// Holds NUM_VC independent FIFOs in one shared flit memory. Each FIFO is
// DEPTH flits deep. There is one write port and one read port, and each is
// steered by a channel index. Per-channel status flags are combinational
// from the fill counts. A registered credit pulse goes back upstream for
// every freed slot.
// Optional build macro VC_QUEUE_STATS_EN adds the ovf_err and drop_cnt
// outputs, which count writes dropped against a full channel.
module vc_queue #(
    parameter int BUS_SIZE  = 32,
    parameter int PTR_SIZE  = 5,
    parameter int VC_W      = 2,
    parameter int AF_THRESH = 2**PTR_SIZE - 2,
    localparam int NUM_VC   = 2**VC_W
) (
    input  logic                clk,
    input  logic                a_rst_n,
    input  logic                wr_req,
    input  logic [VC_W-1:0]     wr_vc,
    input  logic [BUS_SIZE-1:0] data_i,
    input  logic                rd_req,
    input  logic [VC_W-1:0]     rd_vc,
    output logic [BUS_SIZE-1:0] data_o,
    output logic [NUM_VC-1:0]   full,
    output logic [NUM_VC-1:0]   empty,
    output logic [NUM_VC-1:0]   almost_full,
    output logic [NUM_VC-1:0]   credit_o
`ifdef VC_QUEUE_STATS_EN
    ,
    output logic                ovf_err,
    output logic [15:0]         drop_cnt
`endif
);

    localparam int DEPTH  = 2**PTR_SIZE;
    localparam int FILL_W = PTR_SIZE + 1;

    // Channel index in the upper address bits, slot pointer in the lower bits.
    logic [BUS_SIZE-1:0] mem [NUM_VC*DEPTH];

    logic [PTR_SIZE-1:0] wr_ptr [NUM_VC];
    logic [PTR_SIZE-1:0] r_ptr  [NUM_VC];
    logic [FILL_W-1:0]   fill   [NUM_VC];

    logic              pop_ok;
    logic              wr_ok;
    logic [NUM_VC-1:0] wr_hit;
    logic [NUM_VC-1:0] pop_hit;

    // A pop frees a slot in the same cycle, so a full channel still accepts
    // a write when that channel is also being popped.
    assign pop_ok = rd_req & ~empty[rd_vc];
    assign wr_ok  = wr_req & (~full[wr_vc] | (pop_ok & (rd_vc == wr_vc)));

    // Read the head flit of the selected channel with zero latency.
    assign data_o = mem[{rd_vc, r_ptr[rd_vc]}];

    // Build per-channel status flags from the fill counts, and one-hot
    // strobes for the channels that take the accepted write and pop.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned infers a latch.
        wr_hit  = '0;
        pop_hit = '0;
        wr_hit[wr_vc]  = wr_ok;
        pop_hit[rd_vc] = pop_ok;
        for (int v = 0; v < NUM_VC; v++) begin
            full[v]        = (fill[v] == FILL_W'(DEPTH));
            empty[v]       = (fill[v] == '0);
            almost_full[v] = (fill[v] >= FILL_W'(AF_THRESH));
        end
    end

    // Store accepted flits at the tail of the target channel.
    // NOTE: the flit memory has no reset. Pointers and fill counts decide
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[{wr_vc, wr_ptr[wr_vc]}] <= data_i;
    end

    // Advance the pointers, track fill and register the credit pulses.
    always_ff @(posedge clk or negedge a_rst_n) begin
        // NOTE: state registers use non-blocking assignments. Then every
        // register samples the values from before the edge, whatever order
        // the statements are in.
        if (!a_rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                r_ptr[v]  <= '0;
                fill[v]   <= '0;
            end
            credit_o <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_hit[v])
                    wr_ptr[v] <= wr_ptr[v] + PTR_SIZE'(1);
                if (pop_hit[v])
                    r_ptr[v] <= r_ptr[v] + PTR_SIZE'(1);
                if (wr_hit[v] && !pop_hit[v])
                    fill[v] <= fill[v] + FILL_W'(1);
                else if (!wr_hit[v] && pop_hit[v])
                    fill[v] <= fill[v] - FILL_W'(1);
            end
            credit_o <= pop_hit;
        end
    end

`ifdef VC_QUEUE_STATS_EN
    logic drop;

    // A write request that is not accepted is a dropped write. A pop of an
    // empty channel is not a drop.
    assign drop = wr_req & ~wr_ok;

    // Sticky overflow flag and a saturating count of dropped writes.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            ovf_err  <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf_err <= 1'b1;
            if (drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vc_queue.sv
// tb_vc_queue: self-checking bench for vc_queue.
// The reference model holds one queue of flits per channel and uses queue
// sizes for the flags. Stimulus is directed, plus $urandom traffic.
module tb_vc_queue;

    localparam int BUS   = 32;
    localparam int PTR   = 5;
    localparam int VCW   = 2;
    localparam int NVC   = 4;
    localparam int DEPTH = 32;
    localparam int AFT   = 30;

    logic           clk = 1'b0;
    logic           a_rst_n = 1'b0;
    logic           wr_req = 1'b0;
    logic [VCW-1:0] wr_vc = '0;
    logic [BUS-1:0] data_i = '0;
    logic           rd_req = 1'b0;
    logic [VCW-1:0] rd_vc = '0;
    logic [BUS-1:0] data_o;
    logic [NVC-1:0] full;
    logic [NVC-1:0] empty;
    logic [NVC-1:0] almost_full;
    logic [NVC-1:0] credit_o;
`ifdef VC_QUEUE_STATS_EN
    logic           ovf_err;
    logic [15:0]    drop_cnt;
`endif

    // Reference model: one flit queue per channel, plus the expected credit
    // pulse and the dropped-write count.
    logic [BUS-1:0] mq [NVC][$];
    logic [NVC-1:0] exp_credit = '0;
    int             model_drops = 0;

    int n_cmp = 0;
    int n_bad = 0;

    vc_queue #(
        .BUS_SIZE (BUS),
        .PTR_SIZE (PTR),
        .VC_W     (VCW),
        .AF_THRESH(AFT)
    ) dut (
        .clk        (clk),
        .a_rst_n    (a_rst_n),
        .wr_req     (wr_req),
        .wr_vc      (wr_vc),
        .data_i     (data_i),
        .rd_req     (rd_req),
        .rd_vc      (rd_vc),
        .data_o     (data_o),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .credit_o   (credit_o)
`ifdef VC_QUEUE_STATS_EN
        ,
        .ovf_err    (ovf_err),
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [NVC-1:0] m_empty();
        logic [NVC-1:0] r;
        for (int v = 0; v < NVC; v++) r[v] = (mq[v].size() == 0);
        return r;
    endfunction

    function automatic logic [NVC-1:0] m_full();
        logic [NVC-1:0] r;
        for (int v = 0; v < NVC; v++) r[v] = (mq[v].size() == DEPTH);
        return r;
    endfunction

    function automatic logic [NVC-1:0] m_af();
        logic [NVC-1:0] r;
        for (int v = 0; v < NVC; v++) r[v] = (mq[v].size() >= AFT);
        return r;
    endfunction

    // One clock cycle of stimulus. It applies the request, updates the
    // model, and returns at the following negedge.
    task automatic cycle(input logic w, input logic [VCW-1:0] wv, input logic [BUS-1:0] d,
                         input logic r, input logic [VCW-1:0] rv);
        logic p_ok;
        logic w_ok;
        wr_req = w; wr_vc = wv; data_i = d; rd_req = r; rd_vc = rv;
        p_ok = r && (mq[rv].size() != 0);
        w_ok = w && ((mq[wv].size() < DEPTH) || (p_ok && rv == wv));
        @(posedge clk);
        if (p_ok) void'(mq[rv].pop_front());
        if (w_ok) mq[wv].push_back(d);
        if (w && !w_ok && model_drops < 65535) model_drops++;
        exp_credit = '0;
        if (p_ok) exp_credit[rv] = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    // Apply reset at a negedge and release it at the next negedge.
    task automatic do_reset();
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        a_rst_n = 1'b0;
        for (int v = 0; v < NVC; v++) mq[v].delete();
        exp_credit = '0;
        model_drops = 0;
        @(negedge clk);
        a_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (empty !== 4'b1111) begin n_bad++; $display("FAIL reset_empty: got %b want 1111", empty); end
        n_cmp++;
        if (full !== 4'b0000 || almost_full !== 4'b0000 || credit_o !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: full %b af %b credit %b want 0", full, almost_full, credit_o);
        end
        // Put three flits in channel 1, then pull reset in the middle of a cycle.
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd1, $urandom, 1'b0, 2'd0);
        rd_vc = 2'd1;
        #1;
        n_cmp++;
        if (empty[1] !== 1'b0 || data_o !== mq[1][0]) begin
            n_bad++; $display("FAIL pre_reset_ch1: empty %b data %h want 0 %h", empty[1], data_o, mq[1][0]);
        end
        #1;
        a_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (empty[1] !== 1'b1 || empty !== 4'b1111) begin
            n_bad++; $display("FAIL async_reset_empty: got %b want 1111", empty);
        end
        for (int v = 0; v < NVC; v++) mq[v].delete();
        model_drops = 0;
        // A write held while reset is low must be ignored.
        wr_req = 1'b1; wr_vc = 2'd2; data_i = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        wr_req = 1'b0;
        a_rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (empty !== 4'b1111 || credit_o !== 4'b0000) begin
            n_bad++; $display("FAIL write_in_reset: empty %b credit %b want 1111 0000", empty, credit_o);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 2'd2, BUS'(i), 1'b0, 2'd2);
            n_cmp++;
            if (almost_full !== m_af()) begin
                n_bad++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, m_af());
            end
        end
        n_cmp++;
        if (full !== 4'b0100) begin n_bad++; $display("FAIL fill_full: got %b want 0100", full); end
        cycle(1'b1, 2'd2, 32'd99, 1'b0, 2'd2);
        n_cmp++;
        if (full !== 4'b0100 || mq[2].size() != DEPTH) begin
            n_bad++; $display("FAIL fill_drop: full %b want 0100", full);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_vc = 2'd2;
            #1;
            n_cmp++;
            if (data_o !== BUS'(i)) begin n_bad++; $display("FAIL fill_pop[%0d]: got %h want %h", i, data_o, i); end
            cycle(1'b0, 2'd0, '0, 1'b1, 2'd2);
            n_cmp++;
            if (credit_o !== exp_credit) begin
                n_bad++; $display("FAIL fill_credit[%0d]: got %b want %b", i, credit_o, exp_credit);
            end
        end
        n_cmp++;
        if (empty[2] !== 1'b1) begin n_bad++; $display("FAIL fill_empty: got %b want 1", empty[2]); end
        cycle(1'b0, 2'd0, '0, 1'b0, 2'd2);
        n_cmp++;
        if (credit_o !== 4'b0000) begin n_bad++; $display("FAIL fill_credit_idle: got %b want 0000", credit_o); end
    endtask

    task automatic test_same_cycle_full();
        logic [BUS-1:0] last;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 2'd2, $urandom, 1'b0, 2'd2);
        cycle(1'b1, 2'd2, 32'd77, 1'b1, 2'd2);
        n_cmp++;
        if (full[2] !== 1'b1 || data_o !== mq[2][0]) begin
            n_bad++; $display("FAIL wp_full: full %b head %h want 1 %h", full[2], data_o, mq[2][0]);
        end
        last = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_vc = 2'd2;
            #1;
            n_cmp++;
            if (data_o !== mq[2][0]) begin n_bad++; $display("FAIL wp_pop[%0d]: got %h want %h", i, data_o, mq[2][0]); end
            last = data_o;
            cycle(1'b0, 2'd0, '0, 1'b1, 2'd2);
        end
        n_cmp++;
        if (last !== 32'd77 || empty[2] !== 1'b1) begin
            n_bad++; $display("FAIL wp_last: got %h empty %b want 77 1", last, empty[2]);
        end
    endtask

    task automatic test_interleave();
        logic [BUS-1:0] a0, a1, b0, b1;
        a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
        cycle(1'b1, 2'd0, a0, 1'b0, 2'd0);
        cycle(1'b1, 2'd3, b0, 1'b0, 2'd0);
        cycle(1'b1, 2'd0, a1, 1'b0, 2'd0);
        cycle(1'b1, 2'd3, b1, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            logic [VCW-1:0] ch;
            logic [BUS-1:0] want;
            ch = (i < 2) ? 2'd0 : 2'd3;
            want = (i == 0) ? a0 : (i == 1) ? a1 : (i == 2) ? b0 : b1;
            rd_vc = ch;
            #1;
            n_cmp++;
            if (data_o !== want) begin n_bad++; $display("FAIL ilv_pop[%0d]: got %h want %h", i, data_o, want); end
            cycle(1'b0, 2'd0, '0, 1'b1, ch);
        end
        cycle(1'b0, 2'd0, '0, 1'b1, 2'd1);
        n_cmp++;
        if (credit_o !== 4'b0000 || empty !== 4'b1111 || full !== 4'b0000) begin
            n_bad++; $display("FAIL empty_pop: credit %b empty %b full %b want 0000 1111 0000", credit_o, empty, full);
        end
    endtask

    task automatic test_wrap();
        int written = 0;
        while (written < 100 || mq[0].size() > 0) begin
            int  sz;
            logic w, r;
            sz = mq[0].size();
            r = (sz > 0) && (sz == 3 || written >= 100 || $urandom_range(0, 1) == 1);
            w = (written < 100) && (sz == 0 || (sz == 1 && r) || $urandom_range(0, 1) == 1);
            rd_vc = 2'd0;
            #1;
            if (r) begin
                n_cmp++;
                if (data_o !== mq[0][0]) begin n_bad++; $display("FAIL wrap_data: got %h want %h", data_o, mq[0][0]); end
            end
            cycle(w, 2'd0, $urandom, r, 2'd0);
            if (w) written++;
            n_cmp++;
            if (empty !== m_empty() || credit_o !== exp_credit) begin
                n_bad++; $display("FAIL wrap_state: empty %b credit %b want %b %b", empty, credit_o, m_empty(), exp_credit);
            end
        end
        n_cmp++;
        if (empty[0] !== 1'b1) begin n_bad++; $display("FAIL wrap_drained: got %b want 1", empty[0]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic w, r;
            logic [VCW-1:0] wv, rv;
            w = ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 99) < 45);
            wv = VCW'($urandom_range(0, NVC - 1));
            rv = VCW'($urandom_range(0, NVC - 1));
            rd_vc = rv;
            #1;
            if (r && mq[rv].size() != 0) begin
                n_cmp++;
                if (data_o !== mq[rv][0]) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h want %h", i, data_o, mq[rv][0]); end
            end
            cycle(w, wv, $urandom, r, rv);
            n_cmp++;
            if (empty !== m_empty() || full !== m_full() || almost_full !== m_af() || credit_o !== exp_credit) begin
                n_bad++;
                $display("FAIL rnd_flags[%0d]: e %b f %b af %b c %b want %b %b %b %b", i,
                         empty, full, almost_full, credit_o, m_empty(), m_full(), m_af(), exp_credit);
            end
        end
    endtask

`ifdef VC_QUEUE_STATS_EN
    task automatic test_stats();
        do_reset();
        n_cmp++;
        if (ovf_err !== 1'b0 || drop_cnt !== 16'd0) begin
            n_bad++; $display("FAIL stats_reset: ovf %b cnt %0d want 0 0", ovf_err, drop_cnt);
        end
        cycle(1'b0, 2'd0, '0, 1'b1, 2'd1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 2'd1, $urandom, 1'b0, 2'd1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'd1, $urandom, 1'b0, 2'd1);
        n_cmp++;
        if (ovf_err !== 1'b1 || drop_cnt !== 16'(model_drops) || drop_cnt !== 16'd5) begin
            n_bad++; $display("FAIL stats_drops: ovf %b cnt %0d want 1 5", ovf_err, drop_cnt);
        end
        do_reset();
        n_cmp++;
        if (ovf_err !== 1'b0 || drop_cnt !== 16'd0) begin
            n_bad++; $display("FAIL stats_clear: ovf %b cnt %0d want 0 0", ovf_err, drop_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_same_cycle_full();
        test_interleave();
        test_wrap();
        test_random();
`ifdef VC_QUEUE_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vc_queue.md
Name: vc_queue

Overview:
- Multi-channel input buffer for a switch port.
- Holds 2**VC_W independent virtual-channel FIFOs, each 2**PTR_SIZE entries deep and BUS_SIZE bits wide.
- One write port and one read port, each steered by a channel index.
- Per-channel status flags and a registered per-channel credit pulse back toward the upstream sender.

Parameters:
- BUS_SIZE, 32, flit width in bits.
- PTR_SIZE, 5, log2 of the per-channel depth; depth = 2**PTR_SIZE.
- VC_W, 2, log2 of the channel count; NUM_VC = 2**VC_W.
- AF_THRESH, 2**PTR_SIZE-2, per-channel fill level at or above which almost_full asserts; legal range 1..2**PTR_SIZE.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- a_rst_n  in  1  reset, asynchronous, active-low.
- wr_req  in  1  write request for channel wr_vc.
- wr_vc  in  VC_W  target channel of the write.
- data_i  in  BUS_SIZE  flit to store.
- rd_req  in  1  pop request for channel rd_vc.
- rd_vc  in  VC_W  channel being read.
- data_o  out  BUS_SIZE  head flit of channel rd_vc, combinational read.
- full  out  NUM_VC  per-channel full flag, bit v = channel v.
- empty  out  NUM_VC  per-channel empty flag.
- almost_full  out  NUM_VC  per-channel fill >= AF_THRESH.
- credit_o  out  NUM_VC  one-cycle pulse per freed slot.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Per channel v, the block holds wr_ptr[v] and r_ptr[v] (PTR_SIZE bits, wrap modulo depth) and fill[v] (PTR_SIZE+1 bits).
- Reset (a_rst_n=0, takes effect immediately, independent of clk):
  - all pointers and fills go to 0, credit_o goes to 0;
  - so empty = all ones, full = 0, almost_full = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored flits. Writes and pops presented while reset is low are ignored.
- Flags are combinational from fill:
  - full[v] = (fill[v] == 2**PTR_SIZE)
  - empty[v] = (fill[v] == 0)
  - almost_full[v] = (fill[v] >= AF_THRESH)
- Pop:
  - pop_ok = rd_req & ~empty[rd_vc].
  - On pop_ok, r_ptr[rd_vc] increments and fill decrements at the clock edge.
  - A pop of an empty channel is ignored: no pointer change, no credit.
- Write:
  - wr_ok = wr_req & (~full[wr_vc] | (pop_ok & rd_vc == wr_vc)).
  - On wr_ok, data_i is stored at wr_ptr[wr_vc], the pointer increments and fill increments.
  - A write to a full channel without a same-channel pop is dropped silently.
- Simultaneous events:
  - Write and pop on the same channel in one cycle: fill unchanged, both pointers advance.
  - This includes a full channel (write accepted) and a channel with fill = 1.
  - An empty channel cannot pop, so a same-cycle write to it only writes.
  - Write and pop on different channels update independently.
- Read latency:
  - data_o = mem[rd_vc][r_ptr[rd_vc]], combinational, zero cycles.
  - A flit written at edge N is visible on data_o after edge N when that channel was empty.
  - data_o is don't-care while empty[rd_vc] = 1.
- Credits:
  - credit_o is registered; bit v pulses high for exactly the one cycle after a pop_ok on channel v.
  - Consecutive pops give consecutive pulses.
- Wrap-around: pointers roll from 2**PTR_SIZE-1 to 0 with no loss of ordering. Per-channel order is strict FIFO.

Optional Feature:
- Macro VC_QUEUE_STATS_EN.
- When defined, two extra outputs follow credit_o:
  - ovf_err, 1 bit: sticky, set on any dropped write.
  - drop_cnt, 16 bits: counts dropped writes and saturates at 16'hFFFF.
  - Both clear only on reset. A pop of an empty channel does not count.
- When undefined, neither port nor logic exists; behaviour is otherwise identical.

Test Plan:
1. Reset then idle:
   - Required: empty = 4'b1111, full = 0, almost_full = 0, credit_o = 0.
   - Assert a_rst_n=0 mid-cycle with channel 1 holding 3 flits; empty[1] = 1 immediately, without waiting for a clock edge.
2. Fill channel 2 with 32 writes of data 0..31:
   - full = 4'b0100; almost_full[2] sets after the 30th write.
   - A 33rd write (value 99) is dropped.
   - Pop 32: data_o sequence is 0..31, then empty[2] = 1.
   - credit_o[2] pulses 32 cycles, each one cycle after its pop.
3. With channel 2 full: same-cycle write 77 + pop.
   - Required: full[2] stays 1, head advances, 77 emerges as the last of 32 pops.
4. Interleave writes to channels 0 and 3 (A0,B0,A1,B1):
   - rd_vc=0 yields A0,A1; rd_vc=3 yields B0,B1; no cross-channel mixing.
   - Pop of empty channel 1 gives no credit_o[1] and no state change.
5. Wrap-around: run 100 write/pop pairs through channel 0 with fill held at 1..3.
   - Output order matches input order; fill returns to 0.
6. With VC_QUEUE_STATS_EN: 5 writes to a full channel.
   - Required: ovf_err = 1, drop_cnt = 5.
   - After reset, ovf_err = 0 and drop_cnt = 0.
